// File: rtl/uncore_pkg.sv
// -----------------------------------------------------------------------------
// uncore_pkg
// Shared definitions for the uncore byte-stream blocks:
//   BYTE_WIDTH_DEFAULT  default byte width of the UART-facing stream
//   serializer_state_t  two-state FSM encoding of the word/byte serializer
//   idx_width()         width of a byte index covering n bytes (at least 1)
// -----------------------------------------------------------------------------
package uncore_pkg;

  localparam int BYTE_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } serializer_state_t;

  // A one-byte word would give $clog2 == 0; keep the index at least one bit.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_byte_serializer_if.sv
// -----------------------------------------------------------------------------
// word_byte_serializer_if
// Word-in / byte-out handshake bundle of the serializer.
//   word_in, word_valid, word_ready : upstream packed-word handshake
//   byte_out, byte_valid, byte_ready: downstream byte handshake (UART TX)
//   busy                            : a word is being serialized
// Modports: slave = serializer, master = the surrounding logic.
// -----------------------------------------------------------------------------
interface word_byte_serializer_if #(
  parameter int NUM_BYTES  = 4,
  parameter int BYTE_WIDTH = uncore_pkg::BYTE_WIDTH_DEFAULT
);

  logic [NUM_BYTES*BYTE_WIDTH-1:0] word_in;
  logic                            word_valid;
  logic                            word_ready;
  logic [BYTE_WIDTH-1:0]           byte_out;
  logic                            byte_valid;
  logic                            byte_ready;
  logic                            busy;

  modport slave (
    input  word_in, word_valid, byte_ready,
    output word_ready, byte_out, byte_valid, busy
  );

  modport master (
    output word_in, word_valid, byte_ready,
    input  word_ready, byte_out, byte_valid, busy
  );

endinterface

// File: rtl/word_byte_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
// Takes one NUM_BYTES*BYTE_WIDTH word over a valid/ready handshake and emits
// it one byte per transfer over a second valid/ready handshake. A new word is
// accepted in the same cycle the last byte of the current word transfers, so
// sustained throughput is one byte per cycle.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset; discards any partial word
//   bus    word_byte_serializer_if.slave (word in, byte out, busy)
// -----------------------------------------------------------------------------
module word_byte_serializer
  import uncore_pkg::*;
#(
  parameter int NUM_BYTES  = 4,
  parameter int BYTE_WIDTH = BYTE_WIDTH_DEFAULT,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  word_byte_serializer_if.slave       bus
);

  localparam int              WORD_W   = NUM_BYTES * BYTE_WIDTH;
  localparam int              IDX_W    = idx_width(NUM_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  serializer_state_t state, state_next;
  logic [WORD_W-1:0] shreg, shreg_next;
  logic [IDX_W-1:0]  idx, idx_next;

  logic byte_xfer;
  logic word_xfer;
  logic at_last;

  assign at_last   = (idx == LAST_IDX);
  assign byte_xfer = bus.byte_valid && bus.byte_ready;
  assign word_xfer = bus.word_valid && bus.word_ready;

  // Ready early in the last-byte cycle so the next word lands with no bubble;
  // held low during reset so nothing is accepted while the block is cleared.
  assign bus.word_ready = rst_n &&
                          ((state == IDLE) ||
                           ((state == SEND) && bus.byte_ready && at_last));

  // Outputs come straight from registers, so they cannot glitch or change
  // while the downstream stalls.
  assign bus.byte_valid = (state == SEND);
  assign bus.busy       = (state == SEND);
  assign bus.byte_out   = MSB_FIRST ? shreg[WORD_W-1 -: BYTE_WIDTH]
                                    : shreg[BYTE_WIDTH-1:0];

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (word_xfer) begin
          shreg_next = bus.word_in;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (byte_xfer) begin
          if (!at_last) begin
            // Zero-fill: the emitting end always holds the next byte.
            shreg_next = MSB_FIRST ? (shreg << BYTE_WIDTH) : (shreg >> BYTE_WIDTH);
            idx_next   = idx + IDX_W'(1);
          end else if (word_xfer) begin
            shreg_next = bus.word_in;
            idx_next   = '0;
          end else begin
            idx_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from the values computed in the previous cycle. The shift
  // register is reset too, because byte_out must read 0 during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      idx   <= idx_next;
    end
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_byte_serializer
// Directed bench for word_byte_serializer: an MSB-first instance for the main
// sequences and an LSB-first instance for the byte-order check. A negedge
// monitor records every byte transfer and checks stall stability.
// -----------------------------------------------------------------------------
module tb_word_byte_serializer;
  import uncore_pkg::*;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  word_byte_serializer_if #(.NUM_BYTES(4), .BYTE_WIDTH(8)) bus  ();
  word_byte_serializer_if #(.NUM_BYTES(4), .BYTE_WIDTH(8)) bus2 ();

  word_byte_serializer #(.NUM_BYTES(4), .BYTE_WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  word_byte_serializer #(.NUM_BYTES(4), .BYTE_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (negedge, away from the active edge) ------------
  logic [7:0] q[$];
  int         q_cyc[$];
  int         cyc      = 0;
  int         busy_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (bus.busy) busy_cnt++;
    if (prev_stall) begin
      check("stall_valid", {31'd0, bus.byte_valid}, 32'd1);
      check("stall_hold", {24'd0, bus.byte_out}, {24'd0, prev_byte});
    end
    if (bus.byte_valid && !bus.byte_ready)
      check("stall_word_ready", {31'd0, bus.word_ready}, 32'd0);
    if (bus.byte_valid && bus.byte_ready) begin
      q.push_back(bus.byte_out);
      q_cyc.push_back(cyc);
    end
    prev_stall = rst_n && bus.byte_valid && !bus.byte_ready;
    prev_byte  = bus.byte_out;
  end

  // ---------------- helpers -------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q.delete();
    q_cyc.delete();
    busy_cnt = 0;
  endtask

  // Present a word and hold it until accepted; returns at posedge+1 after the
  // accepting edge with word_valid dropped.
  task automatic send_word(input logic [31:0] w, output logic [7:0] acc_byte);
    bit done = 0;
    bus.word_in    = w;
    bus.word_valid = 1'b1;
    acc_byte       = 8'h00;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.word_ready) begin
        acc_byte = bus.byte_out;
        done = 1;
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    tick();
    bus.word_valid = 1'b0;
  endtask

  // Check four logged bytes starting at base against w, MSB first.
  task automatic check_word(input string tag, input int base, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_b;
      exp_b = (w >> (8 * (3 - i))) & 32'hFF;
      if (base + i < q.size())
        check(tag, {24'd0, q[base+i]}, exp_b);
      else
        check(tag, 32'hDEAD, exp_b);
    end
  endtask

  // ---------------- stimulus ------------------------------------------------
  logic [7:0] acc;

  initial begin
    rst_n           = 1'b0;
    bus.word_in     = '0;
    bus.word_valid  = 1'b0;
    bus.byte_ready  = 1'b1;
    bus2.word_in    = '0;
    bus2.word_valid = 1'b0;
    bus2.byte_ready = 1'b1;

    // Reset state
    #12;
    check("rst_byte_valid", {31'd0, bus.byte_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_byte_out", {24'd0, bus.byte_out}, 32'd0);
    check("rst_word_ready", {31'd0, bus.word_ready}, 32'd0);
    check("rst_byte_out_lsb", {24'd0, bus2.byte_out}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("idle_word_ready", {31'd0, bus.word_ready}, 32'd1);
    tick();

    // 1: basic word, byte_ready tied high
    clear_log();
    send_word(32'h11121314, acc);
    repeat (6) tick();
    check("t1_len", q.size(), 32'd4);
    check_word("t1_byte", 0, 32'h11121314);
    if (q.size() == 4) check("t1_contig", q_cyc[3] - q_cyc[0], 32'd3);
    check("t1_busy_cycles", busy_cnt, 32'd4);
    check("t1_idle_ready", {31'd0, bus.word_ready}, 32'd1);
    check("t1_idle_busy", {31'd0, bus.busy}, 32'd0);

    // 2: three stall cycles before every byte
    clear_log();
    bus.byte_ready = 1'b0;
    send_word(32'h11121314, acc);
    for (int b = 0; b < 4; b++) begin
      repeat (3) tick();
      bus.byte_ready = 1'b1;
      #1;
      check("t2_ready_last", {31'd0, bus.word_ready}, (b == 3) ? 32'd1 : 32'd0);
      tick();
      bus.byte_ready = 1'b0;
    end
    bus.byte_ready = 1'b1;
    repeat (3) tick();
    check("t2_len", q.size(), 32'd4);
    check_word("t2_byte", 0, 32'h11121314);
    check("t2_busy_cycles", busy_cnt, 32'd16);

    // 3: back-to-back words
    clear_log();
    send_word(32'h11121314, acc);
    send_word(32'h21222324, acc);
    check("t3_accept_at_last", {24'd0, acc}, 32'h14);
    repeat (6) tick();
    check("t3_len", q.size(), 32'd8);
    check_word("t3_w1", 0, 32'h11121314);
    check_word("t3_w2", 4, 32'h21222324);
    if (q.size() == 8) check("t3_no_bubble", q_cyc[7] - q_cyc[0], 32'd7);
    check("t3_busy_cycles", busy_cnt, 32'd8);

    // 4: asynchronous reset mid-word, after 0x12 has transferred
    clear_log();
    send_word(32'h11121314, acc);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_valid", {31'd0, bus.byte_valid}, 32'd0);
    check("t4_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t4_rst_byte", {24'd0, bus.byte_out}, 32'd0);
    check("t4_rst_ready", {31'd0, bus.word_ready}, 32'd0);
    check("t4_sent_before", q.size(), 32'd2);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_log();
    send_word(32'hA1A2A3A4, acc);
    repeat (6) tick();
    check("t4_len", q.size(), 32'd4);
    check_word("t4_byte", 0, 32'hA1A2A3A4);

    // 5: LSB-first instance
    bus2.word_in    = 32'h11121314;
    bus2.word_valid = 1'b1;
    #1;
    check("t5_ready", {31'd0, bus2.word_ready}, 32'd1);
    tick();
    bus2.word_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w5;
      w5 = 32'h11121314;
      #1;
      check("t5_valid", {31'd0, bus2.byte_valid}, 32'd1);
      check("t5_byte", {24'd0, bus2.byte_out}, (w5 >> (8 * i)) & 32'hFF);
      tick();
    end
    #1;
    check("t5_done", {31'd0, bus2.byte_valid}, 32'd0);
    tick();

    // 6: word_valid pulsed while busy is ignored; a held word lands at the last byte
    clear_log();
    send_word(32'h11121314, acc);
    tick();
    bus.word_in    = 32'h55565758;
    bus.word_valid = 1'b1;
    #1;
    check("t6_not_ready", {31'd0, bus.word_ready}, 32'd0);
    tick();
    bus.word_valid = 1'b0;
    send_word(32'h31323334, acc);
    check("t6_accept_at_last", {24'd0, acc}, 32'h14);
    repeat (6) tick();
    check("t6_len", q.size(), 32'd8);
    check_word("t6_w1", 0, 32'h11121314);
    check_word("t6_w2", 4, 32'h31323334);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/word_byte_serializer.md
Name: word_byte_serializer

Overview:
- Downstream consumer of the 32-bit packed word produced by the byte-repeat/increment stage on the iCE40 uncore.
- Accepts one NUM_BYTES-wide word over a valid/ready handshake and emits it one byte at a time over a second valid/ready handshake.
- The byte stream feeds the UART transmitter, which sends the results off-chip.
- Full throughput: a new word is accepted in the cycle its predecessor's last byte completes.

Parameters:
- NUM_BYTES, 4, bytes per input word; must be ≥2.
- BYTE_WIDTH, 8, bits per output byte.
- MSB_FIRST, 1, 1 = most-significant byte emitted first; 0 = least-significant byte first.

Ports:
- clk  input  1  single clock domain; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- word_in  input  NUM_BYTES*BYTE_WIDTH  packed word from upstream.
- word_valid  input  1  word_in holds a valid word.
- word_ready  output  1  block can accept word_in this cycle.
- byte_out  output  BYTE_WIDTH  current byte.
- byte_valid  output  1  byte_out holds a valid byte.
- byte_ready  input  1  downstream (UART TX) accepts byte_out this cycle.
- busy  output  1  a word is being serialized.

Behaviour:
- Fixed interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n low, any time, including mid-word):
  - State goes to IDLE, byte index goes to 0, shift register goes to 0.
  - byte_valid=0, byte_out=0, busy=0.
  - word_ready is forced to 0 while rst_n is low.
  - Any partially sent word is discarded; there is no replay.
- Handshakes: a word transfer occurs when word_valid && word_ready on a rising edge. A byte transfer occurs when byte_valid && byte_ready on a rising edge.
- States:
  - IDLE: byte_valid=0, busy=0, word_ready=1. A word transfer loads the shift register and idx=0, then goes to SEND.
  - SEND: byte_valid=1, busy=1.
    - Byte transfer with idx<NUM_BYTES-1: shift by BYTE_WIDTH toward the emitting end, idx increments, stay in SEND.
    - Byte transfer with idx==NUM_BYTES-1 and no word transfer in the same cycle: go to IDLE.
    - Byte transfer with idx==NUM_BYTES-1 and a word transfer in the same cycle: load the new word, idx=0, stay in SEND (back-to-back).
- word_ready = rst_n && (state==IDLE || (state==SEND && byte_ready && idx==NUM_BYTES-1)). This is a combinational path from byte_ready and is permitted.
- byte_out is driven directly from a register:
  - MSB_FIRST=1: top BYTE_WIDTH bits of the shift register.
  - MSB_FIRST=0: bottom BYTE_WIDTH bits.
  - byte_out and byte_valid must stay stable while byte_valid && !byte_ready; backpressure can last any number of cycles.
- Latency: word accepted at edge N → byte 0 valid from edge N (visible in cycle N+1). Minimum NUM_BYTES cycles per word, so sustained throughput is 1 byte/cycle.
- idx width is clog2(NUM_BYTES). idx never exceeds NUM_BYTES-1; there is no wrap beyond the word.
- word_in is sampled only on a word transfer; it is don't-care at all other times.
- word_valid while not ready: the word is held off with no side effects.
- Shifting fills vacated bits with 0.
- No error outputs; no illegal-state recovery beyond reset. The default case of the state decode returns to IDLE.

Decomposition:
- Shared package uncore_pkg holds:
  - BYTE_WIDTH default constant.
  - Two-state enum serializer_state_t {IDLE, SEND}.
  - Helper function for the clog2 of idx width.
- No sub-module: shift register, counter and FSM are a single flat block. The UART TX connection happens at the parent level.

Test Plan:
1. Reset release, word_in=0x11121314 (upstream x=0x10), byte_ready tied 1 → bytes 0x11,0x12,0x13,0x14 on 4 consecutive cycles; busy high exactly 4 cycles; then IDLE with word_ready=1.
2. Backpressure: same word, byte_ready low for 3 cycles at each byte → byte_out/byte_valid held stable during every stall; sequence still 0x11,0x12,0x13,0x14; word_ready stays 0 until the last byte completes.
3. Back-to-back: word_valid held high with 0x11121314 then 0x21222324, byte_ready=1 → 8 contiguous bytes, no bubble; second word accepted in the same cycle 0x14 transfers.
4. Reset mid-word: assert rst_n low asynchronously (off-edge) after 0x12 is sent → byte_valid, busy and byte_out drop to 0 immediately; after release, word 0xA1A2A3A4 is sent cleanly as 0xA1..0xA4 with no leftover 0x13/0x14.
5. MSB_FIRST=0, word 0x11121314 → bytes 0x14,0x13,0x12,0x11.
6. word_valid pulsed while busy → no acceptance, stream unaffected, and the word is taken once IDLE or at the last-byte cycle.
